wb_trace_monitor: RTL and testbench
===================================

// Module: wb_trace_monitor
// PURPOSE
// - Passive observer on the processor register-file write-back port.
// - Captures every commit (dest reg, data, PC) into a circular buffer.
// - A host or testbench drains the buffer through a pop/valid read port.
// - Sits beside processor; lets benches check architectural results without probing internals.
// PARAMETERS
// - DEPTH   16  buffer entries; power of two, >=2
// - AW      4   pointer width; must equal log2(DEPTH)
// - CNTW    32  width of the commit and drop counters
// PORTS
// - ref_clk     in   1      single clock; all logic on posedge
// - reset       in   1      synchronous, active-high
// - wb_valid    in   1      write-back strobe from processor, one commit per cycle
// - wb_reg      in   5      destination register number
// - wb_data     in   32     value written
// - wb_pc       in   32     PC of committing instruction
// - rd_en       in   1      pop request
// - rd_valid    out  1      rd_* holds a popped entry (1-cycle pulse)
// - rd_reg      out  5      popped dest reg
// - rd_data     out  32     popped data
// - rd_pc       out  32     popped PC
// - count       out  AW+1   entries held, 0..DEPTH
// - empty       out  1      count==0
// - full        out  1      count==DEPTH
// - overflow    out  1      sticky: a commit was dropped
// - commits     out  CNTW   commits observed (accepted + dropped)
// - drops       out  CNTW   commits dropped
// BEHAVIOUR
// - Reset: pointers=0, count=0, empty=1, full=0, overflow=0, rd_valid=0, rd_*=0, commits=0, drops=0.
// - Reset mid-operation discards all contents; the next edge after deassertion is a normal cycle.
// - Push: wb_valid & (!full | pop_ok) writes mem[wptr]; wptr wraps DEPTH-1 -> 0.
// - pop_ok = rd_en & !empty, evaluated on pre-edge state.
// - Pop: on pop_ok, rd_* <= mem[rptr] and rd_valid=1 on the next cycle; rptr wraps.
// - Pop latency: 1 cycle.
// - Push-to-visible latency: 1 cycle; empty, count and full are registered.
// - rd_en when empty: ignored, rd_valid=0, rd_* hold previous value; no bypass of same-cycle push.
// - Push and pop in the same cycle: count unchanged.
// - When full, push and pop in the same cycle: both accepted, no drop.
// - Full & wb_valid & !pop_ok: entry dropped; drops+1; overflow<=1 until reset.
// - commits increments on every wb_valid, independent of buffer state.
// - commits and drops wrap modulo 2^CNTW and do not saturate.
// - Buffer storage is not reset; only pointers and flags are.
// CONFIGURATION
// - Macro WB_FILTER_R0_EN.
// - Defined: wb_valid with wb_reg==0 is ignored entirely: no push, no commits or drops update.
// - Undefined: $zero writes are captured like any other register.
// TESTING
// - Reset, 3 commits (r8=5,r9=7,r10=0xC, pc 0,4,8) -> count=3; 3 pops return r8/5/0, r9/7/4, r10/C/8.
// - 16 commits, no pops -> full=1, overflow=0; commit 17 -> drops=1, overflow=1, commits=17.
// - Full buffer, wb_valid & rd_en same cycle -> count stays 16, drops=0, oldest entry popped.
// - Empty buffer, wb_valid & rd_en same cycle -> rd_valid=0, count=1 next cycle.
// - 40 push/pop pairs crossing the wrap -> data order preserved; pointers wrap at 15->0.
// - Commit r0=0x1234 -> WB_FILTER_R0_EN: count=0, commits=0; without macro: count=1.
// - Reset asserted with count=5 -> next cycle count=0, empty=1, overflow=0, rd_valid=0.

Source files
------------

// File: rtl/wb_trace_monitor.sv
// Passive write-back trace monitor: captures register-file commits into a circular buffer drained via pop/valid.
// Optional macro WB_FILTER_R0_EN drops writes to register 0 before they are counted or stored.
module wb_trace_monitor #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int CNTW  = 32
) (
   input  logic            ref_clk,
   input  logic            reset,
   input  logic            wb_valid,
   input  logic [4:0]      wb_reg,
   input  logic [31:0]     wb_data,
   input  logic [31:0]     wb_pc,
   input  logic            rd_en,
   output logic            rd_valid,
   output logic [4:0]      rd_reg,
   output logic [31:0]     rd_data,
   output logic [31:0]     rd_pc,
   output logic [AW:0]     count,
   output logic            empty,
   output logic            full,
   output logic            overflow,
   output logic [CNTW-1:0] commits,
   output logic [CNTW-1:0] drops
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   // Entry layout: {reg, data, pc}
   logic [68:0]     mem_q [DEPTH];

   logic [AW-1:0]   wptr_q, wptr_d;
   logic [AW-1:0]   rptr_q, rptr_d;
   logic [AW:0]     count_q, count_d;
   logic            empty_q, empty_d;
   logic            full_q, full_d;
   logic            overflow_q, overflow_d;
   logic [CNTW-1:0] commits_q, commits_d;
   logic [CNTW-1:0] drops_q, drops_d;
   logic            rd_valid_q;
   logic [4:0]      rd_reg_q;
   logic [31:0]     rd_data_q;
   logic [31:0]     rd_pc_q;

   logic wb_take;
   logic pop_ok;
   logic push;
   logic drop;

`ifdef WB_FILTER_R0_EN
   assign wb_take = wb_valid && (wb_reg != 5'd0);
`else
   assign wb_take = wb_valid;
`endif

   // A pop frees a slot in the same cycle, so a full buffer still accepts a concurrent push.
   assign pop_ok = rd_en && !empty_q;
   assign push   = wb_take && (!full_q || pop_ok);
   assign drop   = wb_take && full_q && !pop_ok;

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      commits_d  = commits_q;
      drops_d    = drops_q;

      if (push)
         wptr_d = wptr_q + 1'b1;
      if (pop_ok)
         rptr_d = rptr_q + 1'b1;

      if (push && !pop_ok)
         count_d = count_q + 1'b1;
      else if (!push && pop_ok)
         count_d = count_q - 1'b1;

      if (wb_take)
         commits_d = commits_q + 1'b1;
      if (drop) begin
         drops_d    = drops_q + 1'b1;
         overflow_d = 1'b1;
      end

      empty_d = (count_d == '0);
      full_d  = (count_d == DEPTH_C);
   end

   // Storage is intentionally left out of reset so it maps onto block RAM.
   always_ff @(posedge ref_clk) begin
      if (push)
         mem_q[wptr_q] <= {wb_reg, wb_data, wb_pc};
   end

   always_ff @(posedge ref_clk) begin
      if (reset) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         commits_q  <= '0;
         drops_q    <= '0;
         rd_valid_q <= 1'b0;
         rd_reg_q   <= '0;
         rd_data_q  <= '0;
         rd_pc_q    <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
         commits_q  <= commits_d;
         drops_q    <= drops_d;
         rd_valid_q <= pop_ok;
         if (pop_ok)
            {rd_reg_q, rd_data_q, rd_pc_q} <= mem_q[rptr_q];
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_reg   = rd_reg_q;
   assign rd_data  = rd_data_q;
   assign rd_pc    = rd_pc_q;
   assign count    = count_q;
   assign empty    = empty_q;
   assign full     = full_q;
   assign overflow = overflow_q;
   assign commits  = commits_q;
   assign drops    = drops_q;

endmodule

// File: tb/tb_wb_trace_monitor.sv
// Directed bench for wb_trace_monitor: a reference queue receives every accepted commit and is
// popped whenever the monitor presents an entry; flags and counters are checked every cycle.
module tb_wb_trace_monitor;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int CNTW  = 32;

   typedef struct packed {
      logic [4:0]  r;
      logic [31:0] d;
      logic [31:0] pc;
   } ent_t;

   logic            ref_clk = 1'b0;
   logic            reset;
   logic            wb_valid;
   logic [4:0]      wb_reg;
   logic [31:0]     wb_data;
   logic [31:0]     wb_pc;
   logic            rd_en;
   logic            rd_valid;
   logic [4:0]      rd_reg;
   logic [31:0]     rd_data;
   logic [31:0]     rd_pc;
   logic [AW:0]     count;
   logic            empty;
   logic            full;
   logic            overflow;
   logic [CNTW-1:0] commits;
   logic [CNTW-1:0] drops;

   always #5 ref_clk = ~ref_clk;

   wb_trace_monitor #(.DEPTH(DEPTH), .AW(AW), .CNTW(CNTW)) dut (
      .ref_clk  (ref_clk),
      .reset    (reset),
      .wb_valid (wb_valid),
      .wb_reg   (wb_reg),
      .wb_data  (wb_data),
      .wb_pc    (wb_pc),
      .rd_en    (rd_en),
      .rd_valid (rd_valid),
      .rd_reg   (rd_reg),
      .rd_data  (rd_data),
      .rd_pc    (rd_pc),
      .count    (count),
      .empty    (empty),
      .full     (full),
      .overflow (overflow),
      .commits  (commits),
      .drops    (drops)
   );

   ent_t            sb[$];
   int              compared   = 0;
   int              mismatched = 0;
   int              m_count;
   logic [CNTW-1:0] m_commits;
   logic [CNTW-1:0] m_drops;
   logic            m_ovf;
   logic            m_rdv;
   ent_t            m_rd;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      if (rd_valid === 1'b1 && sb.size() > 0)
         m_rd = sb.pop_front();
      check("rd_valid", 64'(rd_valid), 64'(m_rdv));
      check("rd_reg",   64'(rd_reg),   64'(m_rd.r));
      check("rd_data",  64'(rd_data),  64'(m_rd.d));
      check("rd_pc",    64'(rd_pc),    64'(m_rd.pc));
      check("count",    64'(count),    64'(m_count));
      check("empty",    64'(empty),    64'(m_count == 0));
      check("full",     64'(full),     64'(m_count == DEPTH));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("commits",  64'(commits),  64'(m_commits));
      check("drops",    64'(drops),    64'(m_drops));
   endtask

   task automatic do_reset();
      @(negedge ref_clk);
      reset    = 1'b1;
      wb_valid = 1'b0;
      rd_en    = 1'b0;
      sb.delete();
      m_count   = 0;
      m_commits = '0;
      m_drops   = '0;
      m_ovf     = 1'b0;
      m_rdv     = 1'b0;
      m_rd      = '0;
      @(posedge ref_clk);
      #1;
      $display("reset applied");
      check_outputs();
   endtask

   // One clock of stimulus; the reference queue receives the entry the monitor should accept.
   task automatic cyc(input logic wv, input logic [4:0] r, input logic [31:0] d,
                      input logic [31:0] pc, input logic re);
      logic take;
      logic pop_ok;
      @(negedge ref_clk);
      reset    = 1'b0;
      wb_valid = wv;
      wb_reg   = r;
      wb_data  = d;
      wb_pc    = pc;
      rd_en    = re;
      take = wv;
`ifdef WB_FILTER_R0_EN
      if (r == 5'd0)
         take = 1'b0;
`endif
      pop_ok = re && (m_count > 0);
      m_rdv  = pop_ok;
      if (pop_ok)
         m_count--;
      if (take) begin
         m_commits++;
         if (m_count < DEPTH) begin
            sb.push_back('{r: r, d: d, pc: pc});
            m_count++;
         end else begin
            m_drops++;
            m_ovf = 1'b1;
         end
      end
      @(posedge ref_clk);
      #1;
      check_outputs();
      if (rd_valid === 1'b1)
         $display("pop  r%0d data=%h pc=%h count=%0d", rd_reg, rd_data, rd_pc, count);
      else if (wv)
         $display("push r%0d data=%h pc=%h count=%0d", r, d, pc, count);
   endtask

   task automatic pop();
      cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
   endtask

   initial begin
      reset    = 1'b1;
      wb_valid = 1'b0;
      wb_reg   = '0;
      wb_data  = '0;
      wb_pc    = '0;
      rd_en    = 1'b0;
      do_reset();

      // Basic capture and in-order drain.
      cyc(1'b1, 5'd8,  32'd5,   32'd0, 1'b0);
      cyc(1'b1, 5'd9,  32'd7,   32'd4, 1'b0);
      cyc(1'b1, 5'd10, 32'hC,   32'd8, 1'b0);
      repeat (3) pop();

      // Pop from an empty buffer is ignored and rd_* hold.
      pop();

      // Fill to full, then one dropped commit.
      for (int i = 0; i < DEPTH; i++)
         cyc(1'b1, 5'(i + 1), 32'(100 + 3 * i), 32'(32'h100 + 4 * i), 1'b0);
      cyc(1'b1, 5'd31, 32'hDEAD, 32'h200, 1'b0);

      // Full buffer: simultaneous push and pop are both accepted.
      cyc(1'b1, 5'd30, 32'hBEEF, 32'h204, 1'b1);
      repeat (DEPTH) pop();

      // Empty buffer: push with pop gives no bypass.
      cyc(1'b1, 5'd5, 32'h55, 32'h300, 1'b1);
      pop();

      // Sustained push/pop pairs walking the pointers across the wrap.
      cyc(1'b1, 5'd1, 32'h0, 32'h3FC, 1'b0);
      for (int i = 0; i < 40; i++)
         cyc(1'b1, 5'((i % 31) + 1), $urandom, 32'(32'h400 + 4 * i), 1'b1);
      pop();

      // Write to register 0.
      cyc(1'b1, 5'd0, 32'h1234, 32'h500, 1'b0);
      pop();

      // Reset with entries held and overflow set.
      for (int i = 0; i < 5; i++)
         cyc(1'b1, 5'(i + 2), 32'(i), 32'(32'h600 + 4 * i), 1'b0);
      do_reset();
      cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
      cyc(1'b1, 5'd7, 32'h77, 32'h700, 1'b0);
      pop();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
